cp0_regfile: RTL and testbench

- Architectural CP0 register file: the write/update end of the CP0 access path.
- Commits mtc0 writes from WB and exception/eret updates from MEM.
- Runs the Count/Compare timer and samples hardware interrupts.
- Supplies raw register values (read data, Status, Cause, EPC) to the downstream CP0 forwarding logic and an interrupt-pending flag to the exception unit.

---
 rtl/cp0_regfile.sv | 160 ++++++++++++++++
 tb/tb_cp0_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// CP0 architectural register file: mtc0 commit, exception/eret update,
// Count/Compare timer and hardware interrupt sampling.
module cp0_regfile #(
    parameter int unsigned  COUNT_DIV    = 2,
    parameter logic [31:0]  STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cp0_write_en,
    input  logic [4:0]  cp0_write_addr,
    input  logic [31:0] cp0_write_data,
    input  logic [4:0]  cp0_read_addr,
    output logic [31:0] cp0_read_data_o,
    input  logic [5:0]  int_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_delay_slot_i,
    input  logic [31:0] exc_badvaddr_i,
    input  logic        eret_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o,
    output logic        int_pending_o
);

    localparam int unsigned      DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;
    localparam logic [4:0]  EXC_ADES     = 5'd5;

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic [31:0]      status_q, status_d;
    logic [31:0]      epc_q, epc_d;
    logic             bd_q, bd_d;
    logic             ti_q, ti_d;
    logic [5:0]       ip_hw_q, ip_hw_d;
    logic [1:0]       ip_sw_q, ip_sw_d;
    logic [4:0]       exccode_q, exccode_d;
    logic             armed_q, armed_d;
    logic             div_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            armed_q    <= 1'b0;
        end else begin
            div_q      <= div_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        div_wrap   = (div_q == DIV_LAST);
        div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
        count_d    = div_wrap ? count_q + 32'd1 : count_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        status_d   = status_q;
        epc_d      = epc_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_hw_d    = int_i;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        armed_d    = armed_q;

        // Count and Compare both reset to 0; the match only counts once
        // software has programmed Compare, otherwise TI would fire out of reset.
        if (armed_q && (count_q == compare_q)) begin
            ti_d = 1'b1;
        end

        if (cp0_write_en) begin
            case (cp0_write_addr)
                ADDR_BADVADDR: badvaddr_d = cp0_write_data;
                ADDR_COUNT:    count_d    = cp0_write_data;
                ADDR_COMPARE: begin
                    compare_d = cp0_write_data;
                    ti_d      = 1'b0;
                    armed_d   = 1'b1;
                end
                ADDR_STATUS:   status_d = (status_q & ~STATUS_WMASK) | (cp0_write_data & STATUS_WMASK);
                ADDR_CAUSE:    ip_sw_d  = cp0_write_data[9:8];
                ADDR_EPC:      epc_d    = cp0_write_data;
                default: ;
            endcase
        end

        // MEM-stage updates overlay the older WB write field by field.
        if (exc_valid_i) begin
            status_d[1] = 1'b1;
            exccode_d   = exc_code_i;
            if (!status_q[1]) begin
                epc_d = exc_delay_slot_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_d  = exc_delay_slot_i;
            end
            if ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES)) begin
                badvaddr_d = exc_badvaddr_i;
            end
        end else if (eret_i) begin
            status_d[1] = 1'b0;
        end
    end

    assign status_o    = status_q;
    assign epc_o       = epc_q;
    assign timer_int_o = ti_q;
    assign cause_o     = {bd_q, ti_q, 14'b0, ip_hw_q[5] | ti_q, ip_hw_q[4:0],
                          ip_sw_q, 1'b0, exccode_q, 2'b00};

    assign int_pending_o = status_q[0] & ~status_q[1] & (|(cause_o[15:8] & status_q[15:8]));

    always_comb begin
        cp0_read_data_o = '0;
        case (cp0_read_addr)
            ADDR_BADVADDR: cp0_read_data_o = badvaddr_q;
            ADDR_COUNT:    cp0_read_data_o = count_q;
            ADDR_COMPARE:  cp0_read_data_o = compare_q;
            ADDR_STATUS:   cp0_read_data_o = status_q;
            ADDR_CAUSE:    cp0_read_data_o = cause_o;
            ADDR_EPC:      cp0_read_data_o = epc_q;
            default:       cp0_read_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: timer, exceptions, write masks, interrupts, reset.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cp0_write_en;
    logic [4:0]  cp0_write_addr;
    logic [31:0] cp0_write_data;
    logic [4:0]  cp0_read_addr;
    logic [31:0] cp0_read_data_o;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_delay_slot_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int_o;
    logic        int_pending_o;

    int tests = 0;
    int fails = 0;
    logic found;

    always #5 clk = ~clk;

    cp0_regfile #(.COUNT_DIV(2), .STATUS_RESET(32'h0040_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cp0_write_en     (cp0_write_en),
        .cp0_write_addr   (cp0_write_addr),
        .cp0_write_data   (cp0_write_data),
        .cp0_read_addr    (cp0_read_addr),
        .cp0_read_data_o  (cp0_read_data_o),
        .int_i            (int_i),
        .exc_valid_i      (exc_valid_i),
        .exc_code_i       (exc_code_i),
        .exc_pc_i         (exc_pc_i),
        .exc_delay_slot_i (exc_delay_slot_i),
        .exc_badvaddr_i   (exc_badvaddr_i),
        .eret_i           (eret_i),
        .status_o         (status_o),
        .cause_o          (cause_o),
        .epc_o            (epc_o),
        .timer_int_o      (timer_int_o),
        .int_pending_o    (int_pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_read_addr = addr;
        #1;
        chk(tag, cp0_read_data_o, exp);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        cp0_write_en   = 1'b1;
        cp0_write_addr = addr;
        cp0_write_data = data;
        tick(1);
        cp0_write_en   = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bva);
        exc_valid_i      = 1'b1;
        exc_code_i       = code;
        exc_pc_i         = pc;
        exc_delay_slot_i = ds;
        exc_badvaddr_i   = bva;
        tick(1);
        exc_valid_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0;
        cp0_write_en = 1'b0; cp0_write_addr = '0; cp0_write_data = '0;
        cp0_read_addr = '0; int_i = '0;
        exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
        exc_delay_slot_i = 1'b0; exc_badvaddr_i = '0; eret_i = 1'b0;
        #12 rst_n = 1'b1;

        // Reset state and free-running Count
        tick(10);
        rd("count_idle10", 5'd9, 32'd5);
        chk("status_reset", status_o, 32'h0040_0000);
        chk("cause_reset", cause_o, 32'h0);
        chk("pending_reset", {31'b0, int_pending_o}, 32'd0);
        chk("ti_reset", {31'b0, timer_int_o}, 32'd0);

        // Timer match
        wr(5'd11, 32'd8);
        cp0_read_addr = 5'd9;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (cp0_read_data_o == 32'd8) found = 1'b1;
            else tick(1);
        end
        chk("count_reached_8", {31'b0, found}, 32'd1);
        chk("ti_not_yet", {31'b0, timer_int_o}, 32'd0);
        tick(1);
        chk("ti_set", {31'b0, timer_int_o}, 32'd1);
        chk("cause_ti_ip7", cause_o, 32'h4000_8000);
        wr(5'd12, 32'h0000_8001);
        chk("status_im7_ie", status_o, 32'h0040_8001);
        chk("pending_timer", {31'b0, int_pending_o}, 32'd1);
        wr(5'd11, 32'h20);
        chk("ti_cleared", {31'b0, timer_int_o}, 32'd0);
        chk("cause_after_clear", cause_o, 32'h0);
        chk("pending_cleared", {31'b0, int_pending_o}, 32'd0);

        // Asynchronous reset mid-count, then divider restart
        rst_n = 1'b0;
        #2;
        chk("async_status", status_o, 32'h0040_0000);
        rd("async_count", 5'd9, 32'd0);
        rd("async_compare", 5'd11, 32'd0);
        rst_n = 1'b1;
        tick(1);
        rd("count_restart0", 5'd9, 32'd0);
        tick(1);
        rd("count_restart1", 5'd9, 32'd1);

        // Exceptions
        exc(5'd4, 32'hBFC0_0100, 1'b1, 32'h0000_1235);
        chk("epc_ds", epc_o, 32'hBFC0_00FC);
        chk("cause_adel_bd", cause_o, 32'h8000_0010);
        rd("badvaddr_adel", 5'd8, 32'h0000_1235);
        chk("status_exl", status_o, 32'h0040_0002);
        exc(5'd12, 32'h0000_0080, 1'b0, 32'h0000_DEAD);
        chk("epc_nested_hold", epc_o, 32'hBFC0_00FC);
        chk("cause_nested", cause_o, 32'h8000_0030);
        rd("badvaddr_hold", 5'd8, 32'h0000_1235);
        eret_i = 1'b1;
        tick(1);
        eret_i = 1'b0;
        chk("eret_exl0", status_o, 32'h0040_0000);

        // WB mtc0 Status together with a MEM exception
        cp0_write_en = 1'b1; cp0_write_addr = 5'd12; cp0_write_data = 32'h0000_FF03;
        exc(5'd8, 32'h0000_0100, 1'b0, 32'h0);
        cp0_write_en = 1'b0;
        chk("wr_exc_status", status_o, 32'h0040_FF03);
        chk("wr_exc_epc", epc_o, 32'h0000_0100);
        chk("wr_exc_cause", cause_o, 32'h0000_0020);
        chk("wr_exc_pending", {31'b0, int_pending_o}, 32'd0);
        eret_i = 1'b1;
        exc(5'd0, 32'h0000_0200, 1'b0, 32'h0);
        eret_i = 1'b0;
        chk("exc_beats_eret", status_o, 32'h0040_FF03);
        chk("exc_beats_eret_epc", epc_o, 32'h0000_0100);

        // Write masks and unimplemented addresses
        do_reset();
        wr(5'd13, 32'hFFFF_FFFF);
        chk("cause_mask", cause_o, 32'h0000_0300);
        wr(5'd12, 32'hFFFF_FFFF);
        chk("status_mask", status_o, 32'h0040_FF03);
        wr(5'd7, 32'h1234_5678);
        rd("read_addr7", 5'd7, 32'h0);
        rd("read_addr10", 5'd10, 32'h0);

        // Hardware interrupt sampling and Count wrap
        do_reset();
        wr(5'd12, 32'h0000_0401);
        int_i = 6'b000001;
        #1;
        chk("ip2_before_edge", cause_o, 32'h0);
        tick(1);
        chk("ip2_sampled", cause_o, 32'h0000_0400);
        chk("pending_hw", {31'b0, int_pending_o}, 32'd1);
        int_i = 6'b000000;
        tick(1);
        chk("ip2_dropped", cause_o, 32'h0);
        chk("pending_hw_off", {31'b0, int_pending_o}, 32'd0);
        wr(5'd9, 32'hFFFF_FFFF);
        rd("count_loaded", 5'd9, 32'hFFFF_FFFF);
        tick(2);
        rd("count_wrapped", 5'd9, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required $finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
